// File: rtl/sipo_deframer_if.sv
// Bus bundle for the serial deframer: serial line in, one-entry word buffer out.
// The master side is the deframer; the slave side is whoever drives the line and consumes words.
interface sipo_deframer_if #(
  parameter int WIDTH = 4
);
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  // Handshake: a word moves to the consumer on any rising edge where data_valid && data_ready;
  // data_valid, once high, holds with data_out stable until that edge; data_ready alone does nothing.
  modport master (
    input  serial_in, data_ready,
    output data_out, data_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output serial_in, data_ready,
    input  data_out, data_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-to-parallel receive stage: start bit, MSB-first data, optional even parity, stop bit,
// delivered through a one-entry valid/ready buffer with parity, framing and overrun flags.
module sipo_deframer #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  sipo_deframer_if.master   bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_perr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_perr_out;
  logic             r_ferr;
  logic             r_ovr;
  logic             r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_perr     <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_valid && bus.data_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.serial_in) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_DATA: begin
          r_shreg <= {r_shreg[WIDTH-2:0], bus.serial_in};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          r_perr  <= ^{r_shreg, bus.serial_in};
          r_state <= S_STOP;
        end
        S_STOP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          // A load on the same edge as an accept keeps data_valid high with the new word.
          if (bus.serial_in) begin
            r_ferr <= 1'b1;
          end else if (!r_valid || bus.data_ready) begin
            r_data     <= r_shreg;
            r_perr_out <= (PARITY_EN != 0) ? r_perr : 1'b0;
            r_valid    <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.parity_err = r_perr_out;
  assign bus.frame_err  = r_ferr;
  assign bus.overrun    = r_ovr;
  assign bus.busy       = r_busy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: vector table, hand-written corner sequences, and randomized frames
// checked against a frame-level reference model with a word scoreboard.
module tb_sipo_deframer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_deframer_if #(.WIDTH(W)) bus0 ();
  sipo_deframer_if #(.WIDTH(W)) bus1 ();
  logic [1:0] dbg0, dbg1;

  sipo_deframer #(.WIDTH(W), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .o_dbg_state(dbg0)
  );
  sipo_deframer #(.WIDTH(W), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: words held in the output buffer, {parity_err, data}.
  logic [W:0] exp_q[$];
  logic       m_ovr;

  typedef struct {
    logic [6:0] bits;
    logic [3:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus0.serial_in = 1'b0; bus0.data_ready = 1'b0;
    bus1.serial_in = 1'b0; bus1.data_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic send0(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus0.serial_in = bits[i];
      tick;
    end
    bus0.serial_in = 1'b0;
  endtask

  // One randomized cycle: drive the line bit, pick data_ready, advance the model, compare.
  task automatic rcycle(input logic bit_v, input logic is_stop, input logic in_frame,
                        input logic [W-1:0] d, input logic pbit);
    logic       ready;
    logic       exp_ferr;
    logic [W:0] e;
    ready    = ($urandom_range(0, 2) == 0);
    exp_ferr = 1'b0;
    bus0.serial_in  = bit_v;
    bus0.data_ready = ready;
    if (ready && exp_q.size() > 0) begin
      e = exp_q[0];
      check("rnd_accept_data", bus0.data_out, e[W-1:0]);
      void'(exp_q.pop_front());
    end
    if (is_stop) begin
      if (bit_v) exp_ferr = 1'b1;
      else if (exp_q.size() == 0) exp_q.push_back({(^d) ^ pbit, d});
      else m_ovr = 1'b1;
    end
    tick;
    check("rnd_valid", bus0.data_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("rnd_data", bus0.data_out, e[W-1:0]);
      check("rnd_perr", bus0.parity_err, e[W]);
    end
    check("rnd_ferr", bus0.frame_err, exp_ferr);
    check("rnd_ovr", bus0.overrun, m_ovr);
    check("rnd_busy", bus0.busy, in_frame && !is_stop);
  endtask

  initial begin
    logic [6:0] fr;
    logic [3:0] d;
    logic       pbit, stopb;
    int         gap;

    vecs[0] = '{7'b1101110, 4'b1011, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'b1101100, 4'b1011, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{7'b1011001, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{7'b1011000, 4'b0110, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7'b1111100, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{7'b1000010, 4'b0000, 1'b1, 1'b1, 1'b0};

    do_reset;
    check("rst_data",  bus0.data_out, 0);
    check("rst_valid", bus0.data_valid, 0);
    check("rst_perr",  bus0.parity_err, 0);
    check("rst_ferr",  bus0.frame_err, 0);
    check("rst_ovr",   bus0.overrun, 0);
    check("rst_busy",  bus0.busy, 0);
    check("rst1_valid", bus1.data_valid, 0);

    // Vector table: each frame from reset with data_ready low.
    for (int k = 0; k < 6; k++) begin
      do_reset;
      send0({1'b0, vecs[k].bits}, 7);
      check("vec_valid", bus0.data_valid, vecs[k].valid);
      if (vecs[k].valid) check("vec_data", bus0.data_out, vecs[k].data);
      check("vec_perr", bus0.parity_err, vecs[k].perr);
      check("vec_ferr", bus0.frame_err, vecs[k].ferr);
      check("vec_busy", bus0.busy, 0);
      check("vec_ovr",  bus0.overrun, 0);
    end

    // Good frame, then one accept cycle.
    do_reset;
    send0(8'b01101110, 7);
    check("good_valid", bus0.data_valid, 1);
    bus0.data_ready = 1'b1;
    tick;
    bus0.data_ready = 1'b0;
    check("good_consumed", bus0.data_valid, 0);

    // Framing error pulses once, then a following frame still arrives.
    do_reset;
    send0(8'b01011001, 7);
    check("ferr_pulse", bus0.frame_err, 1);
    check("ferr_novalid", bus0.data_valid, 0);
    tick;
    check("ferr_one_cycle", bus0.frame_err, 0);
    send0(8'b01100100, 7);
    check("ferr_next_valid", bus0.data_valid, 1);
    check("ferr_next_data", bus0.data_out, 4'b1001);

    // Overrun: second frame dropped, flag sticky after the buffer drains.
    do_reset;
    send0(8'b01101110, 7);
    send0(8'b01011000, 7);
    check("ovr_data", bus0.data_out, 4'b1011);
    check("ovr_perr", bus0.parity_err, 0);
    check("ovr_flag", bus0.overrun, 1);
    bus0.data_ready = 1'b1;
    tick;
    bus0.data_ready = 1'b0;
    check("ovr_drained", bus0.data_valid, 0);
    check("ovr_sticky", bus0.overrun, 1);

    // Accept and load on the same edge, three back-to-back frames.
    do_reset;
    for (int f = 0; f < 3; f++) begin
      fr = (f == 0) ? 7'b1000110 : (f == 1) ? 7'b1001010 : 7'b1010010;
      for (int i = 6; i >= 0; i--) begin
        bus0.serial_in  = fr[i];
        bus0.data_ready = (i == 0) && (f > 0);
        tick;
        if (f > 0) check("sim_valid_held", bus0.data_valid, 1);
      end
      check("sim_data", bus0.data_out, 4'b0001 << f);
    end
    bus0.serial_in = 1'b0;
    bus0.data_ready = 1'b0;
    check("sim_no_ovr", bus0.overrun, 0);

    // Reset mid-frame with a word already buffered.
    do_reset;
    send0(8'b01101110, 7);
    send0(8'b00000110, 3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_data",  bus0.data_out, 0);
    check("mid_rst_valid", bus0.data_valid, 0);
    check("mid_rst_perr",  bus0.parity_err, 0);
    check("mid_rst_ovr",   bus0.overrun, 0);
    check("mid_rst_busy",  bus0.busy, 0);
    send0(8'b01100100, 7);
    check("mid_rst_next", bus0.data_out, 4'b1001);
    check("mid_rst_next_valid", bus0.data_valid, 1);

    // No-parity instance: six-bit frame.
    do_reset;
    fr = 7'b0110010;
    for (int i = 5; i >= 0; i--) begin
      bus1.serial_in = fr[i];
      tick;
      if (i == 1) check("np_not_yet", bus1.data_valid, 0);
    end
    bus1.serial_in = 1'b0;
    check("np_valid", bus1.data_valid, 1);
    check("np_data",  bus1.data_out, 4'b1001);
    check("np_perr",  bus1.parity_err, 0);
    check("np_busy",  bus1.busy, 0);

    // Randomized frames against the reference model.
    do_reset;
    exp_q.delete();
    m_ovr = 1'b0;
    for (int f = 0; f < 80; f++) begin
      gap   = $urandom_range(0, 2);
      d     = 4'($urandom_range(0, 15));
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 4) == 0);
      for (int g = 0; g < gap; g++) rcycle(1'b0, 1'b0, 1'b0, d, pbit);
      rcycle(1'b1, 1'b0, 1'b1, d, pbit);
      for (int i = W - 1; i >= 0; i--) rcycle(d[i], 1'b0, 1'b1, d, pbit);
      rcycle(pbit, 1'b0, 1'b1, d, pbit);
      rcycle(stopb, 1'b1, 1'b1, d, pbit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
